// File: rtl/usb_transaction_controller.sv
// usb_transaction_controller: sequences full-speed token/data/handshake
// transactions, tracks per-endpoint data toggles, owns the packet buffer
// handoff between the USB receiver and the CPU, and applies the device address.
// Optional build macro USB_ENDPOINT_STALL_EN adds the cpu_stall input and STALL handshakes.
module usb_transaction_controller #(
  parameter int unsigned NUM_ENDPOINTS  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 72
) (
  input  logic       clock48,
  input  logic       reset,
  input  logic       usb_reset,
  input  logic       rx_done,
  input  logic [3:0] rx_pid,
  input  logic [6:0] rx_addr,
  input  logic [3:0] rx_endp,
  input  logic       rx_crc_ok,
  input  logic [6:0] rx_byte_count,
  output logic       rx_buffer_write_enable,
  output logic       tx_start,
  output logic [3:0] tx_pid,
  output logic [6:0] tx_len,
  input  logic       tx_done,
  output logic       cpu_rx_ready,
  output logic [3:0] cpu_rx_endp,
  output logic       cpu_rx_setup,
  output logic [6:0] cpu_rx_len,
  input  logic       cpu_rx_release,
  input  logic       cpu_tx_arm,
  input  logic [3:0] cpu_tx_endp,
  input  logic [6:0] cpu_tx_len,
  output logic       cpu_tx_pending,
  input  logic       cpu_set_address,
  input  logic [6:0] cpu_address,
  output logic [6:0] device_address
`ifdef USB_ENDPOINT_STALL_EN
  ,
  input  logic [NUM_ENDPOINTS-1:0] cpu_stall
`endif
);

  localparam int unsigned NE    = NUM_ENDPOINTS;
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_DATA, S_SEND_HANDSHAKE, S_SEND_DATA, S_WAIT_ACK
  } state_e;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             wr_en_q, wr_en_d;
  logic             tx_start_q, tx_start_d;
  logic [3:0]       tx_pid_q, tx_pid_d;
  logic [6:0]       tx_len_q, tx_len_d;
  logic             rx_ready_q, rx_ready_d;
  logic [3:0]       rx_endp_q, rx_endp_d;
  logic             rx_setup_q, rx_setup_d;
  logic [6:0]       rx_len_q, rx_len_d;
  logic             tx_pend_q, tx_pend_d;
  logic [3:0]       arm_endp_q, arm_endp_d;
  logic [6:0]       arm_len_q, arm_len_d;
  logic [6:0]       dev_addr_q, dev_addr_d;
  logic [6:0]       addr_new_q, addr_new_d;
  logic             addr_vld_q, addr_vld_d;
  logic [NE-1:0]    out_tog_q, out_tog_d;
  logic [NE-1:0]    in_tog_q, in_tog_d;
  logic [3:0]       tok_endp_q, tok_endp_d;
  logic             tok_setup_q, tok_setup_d;
  logic             tok_stall_q, tok_stall_d;
`ifdef USB_ENDPOINT_STALL_EN
  logic             ep0_clr_q, ep0_clr_d;
  logic             stall0_prev_q, stall0_prev_d;
`endif

  logic          token_hit;
  logic          data_ok;
  logic          stall_hit;
  logic [NE-1:0] rx_mask;
  logic [NE-1:0] tok_mask;

  assign rx_buffer_write_enable = wr_en_q;
  assign tx_start               = tx_start_q;
  assign tx_pid                 = tx_pid_q;
  assign tx_len                 = tx_len_q;
  assign cpu_rx_ready           = rx_ready_q;
  assign cpu_rx_endp            = rx_endp_q;
  assign cpu_rx_setup           = rx_setup_q;
  assign cpu_rx_len             = rx_len_q;
  assign cpu_tx_pending         = tx_pend_q;
  assign device_address         = dev_addr_q;

  // Next-state, toggle bookkeeping, buffer handoff and response selection
  always_comb begin
    state_d     = state_q;
    timer_d     = '0;
    wr_en_d     = wr_en_q;
    tx_start_d  = 1'b0;
    tx_pid_d    = tx_pid_q;
    tx_len_d    = tx_len_q;
    rx_ready_d  = rx_ready_q;
    rx_endp_d   = rx_endp_q;
    rx_setup_d  = rx_setup_q;
    rx_len_d    = rx_len_q;
    tx_pend_d   = tx_pend_q;
    arm_endp_d  = arm_endp_q;
    arm_len_d   = arm_len_q;
    dev_addr_d  = dev_addr_q;
    addr_new_d  = addr_new_q;
    addr_vld_d  = addr_vld_q;
    out_tog_d   = out_tog_q;
    in_tog_d    = in_tog_q;
    tok_endp_d  = tok_endp_q;
    tok_setup_d = tok_setup_q;
    tok_stall_d = tok_stall_q;

    rx_mask   = NE'(1) << rx_endp;
    tok_mask  = NE'(1) << tok_endp_q;
    token_hit = rx_done && rx_crc_ok && (rx_addr == dev_addr_q) && (32'(rx_endp) < NE);
    data_ok   = rx_crc_ok && ((rx_pid == PID_DATA0) || (rx_pid == PID_DATA1));

`ifdef USB_ENDPOINT_STALL_EN
    // A SETUP to endpoint 0 masks its stall until the CPU raises the bit again
    stall_hit     = |(cpu_stall & rx_mask & ~(NE'(ep0_clr_q)));
    stall0_prev_d = cpu_stall[0];
    ep0_clr_d     = ep0_clr_q && !(cpu_stall[0] && !stall0_prev_q);
    if (state_q == S_IDLE && token_hit && rx_pid == PID_SETUP && rx_endp == 4'd0) begin
      ep0_clr_d = 1'b1;
    end
`else
    stall_hit = 1'b0;
`endif

    if (cpu_rx_release && !wr_en_q) begin
      rx_ready_d = 1'b0;
      rx_setup_d = 1'b0;
    end
    if (cpu_tx_arm && state_q != S_SEND_DATA && state_q != S_WAIT_ACK) begin
      tx_pend_d  = 1'b1;
      arm_endp_d = cpu_tx_endp;
      arm_len_d  = cpu_tx_len;
    end
    if (cpu_set_address) begin
      addr_new_d = cpu_address;
      addr_vld_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (token_hit) begin
          tok_endp_d  = rx_endp;
          tok_setup_d = (rx_pid == PID_SETUP);
          tok_stall_d = stall_hit && (rx_pid != PID_SETUP);
          if (rx_pid == PID_SETUP) begin
            state_d = S_WAIT_DATA;
            wr_en_d = 1'b1;
          end else if (rx_pid == PID_OUT) begin
            state_d = S_WAIT_DATA;
            wr_en_d = !rx_ready_q && !stall_hit;
          end else if (rx_pid == PID_IN) begin
            tx_start_d = 1'b1;
            if (stall_hit) begin
              state_d  = S_SEND_HANDSHAKE;
              tx_pid_d = PID_STALL;
              tx_len_d = '0;
            end else if (tx_pend_q && arm_endp_q == rx_endp) begin
              state_d  = S_SEND_DATA;
              tx_pid_d = (|(in_tog_q & rx_mask)) ? PID_DATA1 : PID_DATA0;
              tx_len_d = arm_len_q;
            end else begin
              state_d  = S_SEND_HANDSHAKE;
              tx_pid_d = PID_NAK;
              tx_len_d = '0;
            end
          end
        end
      end
      S_WAIT_DATA: begin
        timer_d = timer_q + TMR_W'(1);
        if (rx_done) begin
          state_d = S_IDLE;
          wr_en_d = 1'b0;
          if (data_ok && !(tok_setup_q && rx_pid != PID_DATA0)) begin
            state_d    = S_SEND_HANDSHAKE;
            tx_start_d = 1'b1;
            tx_pid_d   = PID_ACK;
            tx_len_d   = '0;
            if (tok_setup_q) begin
              rx_ready_d = 1'b1;
              rx_setup_d = 1'b1;
              rx_endp_d  = tok_endp_q;
              rx_len_d   = rx_byte_count;
              out_tog_d  = out_tog_q | tok_mask;
              in_tog_d   = in_tog_q | tok_mask;
              if (tx_pend_d && arm_endp_d == tok_endp_q) tx_pend_d = 1'b0;
            end else if (tok_stall_q) begin
              tx_pid_d = PID_STALL;
            end else if (!wr_en_q) begin
              tx_pid_d = PID_NAK;
            end else if ((rx_pid == PID_DATA1) == (|(out_tog_q & tok_mask))) begin
              rx_ready_d = 1'b1;
              rx_setup_d = 1'b0;
              rx_endp_d  = tok_endp_q;
              rx_len_d   = rx_byte_count;
              out_tog_d  = out_tog_q ^ tok_mask;
            end
          end
        end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_IDLE;
          wr_en_d = 1'b0;
        end
      end
      S_SEND_HANDSHAKE: begin
        if (tx_done) state_d = S_IDLE;
      end
      S_SEND_DATA: begin
        if (tx_done) state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        timer_d = timer_q + TMR_W'(1);
        if (rx_done) begin
          state_d = S_IDLE;
          if (rx_pid == PID_ACK && rx_crc_ok) begin
            tx_pend_d = 1'b0;
            in_tog_d  = in_tog_q ^ tok_mask;
            if (addr_vld_q) begin
              dev_addr_d = addr_new_q;
              addr_vld_d = 1'b0;
            end
          end
        end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; bus reset behaves exactly like core reset
  always_ff @(posedge clock48) begin
    if (reset || usb_reset) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      wr_en_q     <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_pid_q    <= '0;
      tx_len_q    <= '0;
      rx_ready_q  <= 1'b0;
      rx_endp_q   <= '0;
      rx_setup_q  <= 1'b0;
      rx_len_q    <= '0;
      tx_pend_q   <= 1'b0;
      arm_endp_q  <= '0;
      arm_len_q   <= '0;
      dev_addr_q  <= '0;
      addr_new_q  <= '0;
      addr_vld_q  <= 1'b0;
      out_tog_q   <= '0;
      in_tog_q    <= '0;
      tok_endp_q  <= '0;
      tok_setup_q <= 1'b0;
      tok_stall_q <= 1'b0;
`ifdef USB_ENDPOINT_STALL_EN
      ep0_clr_q     <= 1'b0;
      stall0_prev_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      wr_en_q     <= wr_en_d;
      tx_start_q  <= tx_start_d;
      tx_pid_q    <= tx_pid_d;
      tx_len_q    <= tx_len_d;
      rx_ready_q  <= rx_ready_d;
      rx_endp_q   <= rx_endp_d;
      rx_setup_q  <= rx_setup_d;
      rx_len_q    <= rx_len_d;
      tx_pend_q   <= tx_pend_d;
      arm_endp_q  <= arm_endp_d;
      arm_len_q   <= arm_len_d;
      dev_addr_q  <= dev_addr_d;
      addr_new_q  <= addr_new_d;
      addr_vld_q  <= addr_vld_d;
      out_tog_q   <= out_tog_d;
      in_tog_q    <= in_tog_d;
      tok_endp_q  <= tok_endp_d;
      tok_setup_q <= tok_setup_d;
      tok_stall_q <= tok_stall_d;
`ifdef USB_ENDPOINT_STALL_EN
      ep0_clr_q     <= ep0_clr_d;
      stall0_prev_q <= stall0_prev_d;
`endif
    end
  end

endmodule

// File: tb/tb_usb_transaction_controller.sv
// Bench for usb_transaction_controller: directed test-plan sequences followed
// by randomized host/CPU traffic, checked against a transaction-level model.
module tb_usb_transaction_controller;

  localparam int unsigned NEP = 2;
  localparam int unsigned TMO = 72;

  localparam logic [3:0] P_OUT = 4'b0001, P_IN  = 4'b1001, P_SETUP = 4'b1101;
  localparam logic [3:0] P_D0  = 4'b0011, P_D1  = 4'b1011;
  localparam logic [3:0] P_ACK = 4'b0010, P_NAK = 4'b1010;

  logic       clk = 1'b0;
  logic       reset, usb_reset;
  logic       rx_done, rx_crc_ok;
  logic [3:0] rx_pid, rx_endp;
  logic [6:0] rx_addr, rx_byte_count;
  logic       rx_buffer_write_enable, tx_start, tx_done;
  logic [3:0] tx_pid;
  logic [6:0] tx_len;
  logic       cpu_rx_ready, cpu_rx_setup, cpu_rx_release;
  logic [3:0] cpu_rx_endp;
  logic [6:0] cpu_rx_len;
  logic       cpu_tx_arm, cpu_tx_pending, cpu_set_address;
  logic [3:0] cpu_tx_endp;
  logic [6:0] cpu_tx_len, cpu_address, device_address;

  always #10 clk = ~clk;

  usb_transaction_controller #(.NUM_ENDPOINTS(NEP), .TIMEOUT_CYCLES(TMO)) dut (
    .clock48(clk), .reset(reset), .usb_reset(usb_reset),
    .rx_done(rx_done), .rx_pid(rx_pid), .rx_addr(rx_addr), .rx_endp(rx_endp),
    .rx_crc_ok(rx_crc_ok), .rx_byte_count(rx_byte_count),
    .rx_buffer_write_enable(rx_buffer_write_enable),
    .tx_start(tx_start), .tx_pid(tx_pid), .tx_len(tx_len), .tx_done(tx_done),
    .cpu_rx_ready(cpu_rx_ready), .cpu_rx_endp(cpu_rx_endp), .cpu_rx_setup(cpu_rx_setup),
    .cpu_rx_len(cpu_rx_len), .cpu_rx_release(cpu_rx_release),
    .cpu_tx_arm(cpu_tx_arm), .cpu_tx_endp(cpu_tx_endp), .cpu_tx_len(cpu_tx_len),
    .cpu_tx_pending(cpu_tx_pending), .cpu_set_address(cpu_set_address),
    .cpu_address(cpu_address), .device_address(device_address)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int tx_cnt   = 0;
  logic [3:0] tx_pid_cap;
  logic [6:0] tx_len_cap;

  // Transaction-level model of the device state
  logic [6:0] m_addr, m_addr_new;
  bit         m_addr_vld;
  bit         m_out_tog[16];
  bit         m_in_tog[16];
  bit         m_ready, m_setup, m_pend;
  logic [3:0] m_rx_ep, m_arm_ep;
  logic [6:0] m_rx_len, m_arm_len;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_addr = '0; m_addr_new = '0; m_addr_vld = 0;
    for (int i = 0; i < 16; i++) begin m_out_tog[i] = 0; m_in_tog[i] = 0; end
    m_ready = 0; m_setup = 0; m_pend = 0;
    m_rx_ep = '0; m_arm_ep = '0; m_rx_len = '0; m_arm_len = '0;
  endfunction

  // One clock; samples 1 time unit after the rising edge and logs tx_start pulses
  task automatic tick();
    @(posedge clk);
    #1;
    if (tx_start) begin
      tx_cnt++;
      tx_pid_cap = tx_pid;
      tx_len_cap = tx_len;
    end
  endtask

  task automatic send_pkt(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] ep,
                          input logic crc, input logic [6:0] len);
    rx_pid = pid; rx_addr = addr; rx_endp = ep; rx_crc_ok = crc; rx_byte_count = len;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic expect_resp(input int c0, input bit resp, input logic [3:0] pid,
                             input logic [6:0] len, input string tag);
    int n;
    if (resp) begin
      n = 0;
      while (tx_cnt == c0 && n < 20) begin tick(); n++; end
      check_eq({tag, "_txcount"}, 32'(tx_cnt - c0), 32'd1);
      check_eq({tag, "_txpid"}, 32'(tx_pid_cap), 32'(pid));
      check_eq({tag, "_txlen"}, 32'(tx_len_cap), 32'(len));
      repeat (3) tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
    end else begin
      repeat (12) tick();
      check_eq({tag, "_noresp"}, 32'(tx_cnt - c0), 32'd0);
    end
  endtask

  task automatic post_check(input string tag);
    tick();
    check_eq({tag, "_ready"},   32'(cpu_rx_ready),   32'(m_ready));
    check_eq({tag, "_setup"},   32'(cpu_rx_setup),   32'(m_setup));
    check_eq({tag, "_rxlen"},   32'(cpu_rx_len),     32'(m_rx_len));
    check_eq({tag, "_rxep"},    32'(cpu_rx_endp),    32'(m_rx_ep));
    check_eq({tag, "_pending"}, 32'(cpu_tx_pending), 32'(m_pend));
    check_eq({tag, "_addr"},    32'(device_address), 32'(m_addr));
    check_eq({tag, "_wr_idle"}, 32'(rx_buffer_write_enable), 32'd0);
  endtask

  // SETUP/OUT token followed by an optional host data packet
  task automatic out_xact(input logic [3:0] tok_pid, input logic [6:0] addr, input logic [3:0] ep,
                          input logic tok_crc, input bit has_data, input logic [3:0] dpid,
                          input logic dcrc, input logic [6:0] dlen, input string tag);
    bit acc, wr, resp;
    logic [3:0] rpid;
    int c0;
    acc = tok_crc && (addr == m_addr) && (32'(ep) < NEP);
    wr  = acc && (tok_pid == P_SETUP || !m_ready);
    c0  = tx_cnt;
    send_pkt(tok_pid, addr, ep, tok_crc, 7'd0);
    check_eq({tag, "_wren"}, 32'(rx_buffer_write_enable), 32'(wr));
    resp = 0;
    rpid = P_ACK;
    if (!has_data) begin
      repeat (TMO + 8) tick();
    end else begin
      send_pkt(dpid, 7'h7f, 4'hf, dcrc, dlen);
      if (acc && dcrc && (dpid == P_D0 || dpid == P_D1)) begin
        if (tok_pid == P_SETUP) begin
          if (dpid == P_D0) begin
            resp = 1;
            m_ready = 1; m_setup = 1; m_rx_ep = ep; m_rx_len = dlen;
            m_out_tog[ep] = 1; m_in_tog[ep] = 1;
            if (m_pend && m_arm_ep == ep) m_pend = 0;
          end
        end else if (!wr) begin
          resp = 1;
          rpid = P_NAK;
        end else begin
          resp = 1;
          if ((dpid == P_D1) == m_out_tog[ep]) begin
            m_ready = 1; m_setup = 0; m_rx_ep = ep; m_rx_len = dlen;
            m_out_tog[ep] = !m_out_tog[ep];
          end
        end
      end
    end
    expect_resp(c0, resp, rpid, 7'd0, tag);
    post_check(tag);
  endtask

  // IN token; hk selects host reply: 0 none, 1 good ACK, 2 ACK with bad CRC, 3 NAK
  task automatic in_xact(input logic [6:0] addr, input logic [3:0] ep, input logic tok_crc,
                         input int hk, input string tag);
    bit acc;
    int c0;
    acc = tok_crc && (addr == m_addr) && (32'(ep) < NEP);
    c0  = tx_cnt;
    send_pkt(P_IN, addr, ep, tok_crc, 7'd0);
    if (!acc) begin
      expect_resp(c0, 0, P_NAK, 7'd0, tag);
    end else if (m_pend && m_arm_ep == ep) begin
      expect_resp(c0, 1, m_in_tog[ep] ? P_D1 : P_D0, m_arm_len, tag);
      check_eq({tag, "_addr_pre"}, 32'(device_address), 32'(m_addr));
      case (hk)
        0: repeat (TMO + 8) tick();
        1: begin
          send_pkt(P_ACK, 7'd0, 4'd0, 1'b1, 7'd0);
          m_pend = 0;
          m_in_tog[ep] = !m_in_tog[ep];
          if (m_addr_vld) begin m_addr = m_addr_new; m_addr_vld = 0; end
        end
        2: send_pkt(P_ACK, 7'd0, 4'd0, 1'b0, 7'd0);
        default: send_pkt(P_NAK, 7'd0, 4'd0, 1'b1, 7'd0);
      endcase
    end else begin
      expect_resp(c0, 1, P_NAK, 7'd0, tag);
    end
    post_check(tag);
  endtask

  task automatic cpu_release();
    cpu_rx_release = 1'b1; tick(); cpu_rx_release = 1'b0;
    m_ready = 0; m_setup = 0;
  endtask

  task automatic cpu_arm(input logic [3:0] ep, input logic [6:0] len);
    cpu_tx_arm = 1'b1; cpu_tx_endp = ep; cpu_tx_len = len; tick(); cpu_tx_arm = 1'b0;
    m_pend = 1; m_arm_ep = ep; m_arm_len = len;
  endtask

  task automatic cpu_set_addr(input logic [6:0] a);
    cpu_set_address = 1'b1; cpu_address = a; tick(); cpu_set_address = 1'b0;
    m_addr_new = a; m_addr_vld = 1;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : main
    int k, hk, r;
    logic [3:0] ep, dpid;
    logic [6:0] a;
    bit tcrc, dcrc, hasd;

    reset = 1; usb_reset = 0; rx_done = 0; rx_pid = '0; rx_addr = '0; rx_endp = '0;
    rx_crc_ok = 0; rx_byte_count = '0; tx_done = 0; cpu_rx_release = 0; cpu_tx_arm = 0;
    cpu_tx_endp = '0; cpu_tx_len = '0; cpu_set_address = 0; cpu_address = '0;
    model_reset();
    repeat (3) tick();
    reset = 0;
    check_eq("rst_txstart", 32'(tx_start), 32'd0);
    check_eq("rst_txpid", 32'(tx_pid), 32'd0);
    check_eq("rst_txlen", 32'(tx_len), 32'd0);
    post_check("rst");

    // Directed sequences
    out_xact(P_SETUP, 7'd0, 4'd0, 1, 1, P_D0, 1, 7'd8, "setup0");
    check_eq("setup0_len8", 32'(cpu_rx_len), 32'd8);
    check_eq("setup0_flag", 32'(cpu_rx_setup), 32'd1);
    out_xact(P_OUT, 7'd0, 4'd1, 1, 1, P_D0, 1, 7'd16, "out_busy");
    check_eq("out_busy_len", 32'(cpu_rx_len), 32'd8);
    cpu_release();
    out_xact(P_OUT, 7'd0, 4'd1, 1, 1, P_D0, 1, 7'd16, "out_ok");
    cpu_release();
    out_xact(P_OUT, 7'd0, 4'd1, 1, 1, P_D0, 1, 7'd20, "out_dup");
    check_eq("out_dup_ready", 32'(cpu_rx_ready), 32'd0);
    in_xact(7'd0, 4'd0, 1, 1, "in_nak");
    cpu_set_addr(7'd5);
    cpu_arm(4'd0, 7'd0);
    in_xact(7'd0, 4'd0, 1, 1, "in_status");
    check_eq("addr_after_status", 32'(device_address), 32'd5);
    out_xact(P_OUT, 7'd0, 4'd0, 1, 1, P_D0, 1, 7'd4, "stale_addr");
    cpu_arm(4'd1, 7'd10);
    in_xact(7'd5, 4'd1, 1, 0, "in_tmo");
    check_eq("in_tmo_pending", 32'(cpu_tx_pending), 32'd1);
    in_xact(7'd5, 4'd1, 1, 1, "in_retry");
    out_xact(P_OUT, 7'd5, 4'd2, 1, 1, P_D0, 1, 7'd3, "bad_ep");

    // Bus reset in the middle of a data phase
    send_pkt(P_SETUP, m_addr, 4'd0, 1'b1, 7'd0);
    check_eq("ureset_wr_before", 32'(rx_buffer_write_enable), 32'd1);
    usb_reset = 1; tick(); usb_reset = 0;
    check_eq("ureset_wr", 32'(rx_buffer_write_enable), 32'd0);
    check_eq("ureset_addr", 32'(device_address), 32'd0);
    model_reset();
    post_check("ureset");
    out_xact(P_SETUP, 7'd0, 4'd0, 1, 1, P_D0, 1, 7'd8, "after_ureset");

    // Randomized traffic
    for (int i = 0; i < 160; i++) begin
      k    = $urandom_range(0, 9);
      ep   = 4'($urandom_range(0, 3));
      a    = ($urandom_range(0, 9) == 0) ? 7'($urandom) : m_addr;
      tcrc = ($urandom_range(0, 9) != 0);
      dcrc = ($urandom_range(0, 9) != 0);
      hasd = ($urandom_range(0, 19) != 0);
      r    = $urandom_range(0, 19);
      dpid = (r < 9) ? P_D0 : (r < 18) ? P_D1 : P_ACK;
      case (k)
        0:       cpu_release();
        1:       cpu_arm(4'($urandom_range(0, 2)), 7'($urandom_range(0, 64)));
        2:       if ($urandom_range(0, 3) == 0) cpu_set_addr(7'($urandom_range(1, 127)));
        3:       out_xact(P_SETUP, a, ep, tcrc, hasd, dpid, dcrc, 7'($urandom_range(0, 64)), "rnd_setup");
        4, 5, 6: out_xact(P_OUT, a, ep, tcrc, hasd, dpid, dcrc, 7'($urandom_range(0, 64)), "rnd_out");
        default: begin
          r  = $urandom_range(0, 9);
          hk = (r < 7) ? 1 : (r == 7) ? 2 : (r == 8) ? 3 : 0;
          in_xact(a, ep, tcrc, hk, "rnd_in");
        end
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_transaction_controller.md
Name: usb_transaction_controller

Overview:
- Sequences USB full-speed transactions (token -> data -> handshake) for the device core, between the packet receiver/transmitter and the CPU-visible packet buffer.
- Decides ACK/NAK/no-response, tracks per-endpoint data toggles, owns the packet buffer handoff between USB receiver and CPU, and applies the device address.
- Runs on the 48 MHz core clock; 1 full-speed bit time is 4 clocks.

Parameters:
- NUM_ENDPOINTS, 2, number of endpoints supported (1..16); tokens to other endpoints are ignored.
- TIMEOUT_CYCLES, 72, clocks to wait for the host data or handshake packet (18 bit times).

Ports:
- clock48  in  1  48 MHz core clock
- reset  in  1  synchronous, active-high reset
- usb_reset  in  1  bus reset detected (SE0 > 2.5 us), level
- rx_done  in  1  1-cycle pulse: receiver finished a packet; rx_* fields valid this cycle
- rx_pid  in  4  PID of received packet (check nibble already verified)
- rx_addr  in  7  token address field
- rx_endp  in  4  token endpoint field
- rx_crc_ok  in  1  CRC5/CRC16 of received packet good
- rx_byte_count  in  7  data payload length, 0..64
- rx_buffer_write_enable  out  1  receiver may write the packet buffer
- tx_start  out  1  1-cycle pulse: send packet
- tx_pid  out  4  PID to send, held from tx_start until tx_done
- tx_len  out  7  payload bytes for DATAx, 0 for handshakes
- tx_done  in  1  1-cycle pulse: transmitter finished EOP
- cpu_rx_ready  out  1  buffer holds received data for the CPU
- cpu_rx_endp  out  4  endpoint of buffered data
- cpu_rx_setup  out  1  buffered data came from SETUP
- cpu_rx_len  out  7  buffered byte count
- cpu_rx_release  in  1  pulse: CPU done with buffer
- cpu_tx_arm  in  1  pulse: CPU loaded IN data
- cpu_tx_endp  in  4  endpoint for armed IN data
- cpu_tx_len  in  7  armed IN length
- cpu_tx_pending  out  1  armed IN data not yet ACKed
- cpu_set_address  in  1  pulse: request address change
- cpu_address  in  7  new address
- device_address  out  7  current address

Behaviour:
- Reset or usb_reset: state IDLE, all outputs 0, device_address 0, all toggles 0, pending address cleared.
- PIDs: OUT 0001, IN 1001, SETUP 1101, DATA0 0011, DATA1 1011, ACK 0010, NAK 1010, STALL 1110.
- States: IDLE, WAIT_DATA, SEND_HANDSHAKE, SEND_DATA, WAIT_ACK.
- IDLE: act only on rx_done with rx_crc_ok, rx_addr == device_address and rx_endp < NUM_ENDPOINTS; everything else is ignored.
  - SETUP -> WAIT_DATA, write enabled unconditionally.
  - OUT -> WAIT_DATA, write enabled only if !cpu_rx_ready.
  - IN -> SEND_DATA if cpu_tx_pending and cpu_tx_endp matches; otherwise SEND_HANDSHAKE with NAK.
- WAIT_DATA:
  - rx_buffer_write_enable asserted from the cycle after the token until rx_done.
  - Next rx_done with a bad CRC or a non-DATAx PID -> IDLE, no response.
  - SETUP: DATA0 required, else IDLE. Overwrites buffer; sets cpu_rx_ready and cpu_rx_setup; sets endpoint out_toggle = 1 and in_toggle = 1; cancels cpu_tx_pending for that endpoint; ACK.
  - OUT, write disabled -> NAK, buffer untouched.
  - OUT, toggle mismatch -> ACK, data discarded, toggle unchanged.
  - OUT, toggle match -> ACK, cpu_rx_ready = 1, toggle flips.
  - No rx_done within TIMEOUT_CYCLES -> IDLE.
- SEND_HANDSHAKE / SEND_DATA:
  - tx_start pulses the cycle after entry; tx_pid = DATA0/DATA1 per in_toggle, tx_len = cpu_tx_len.
  - On tx_done: SEND_HANDSHAKE -> IDLE; SEND_DATA -> WAIT_ACK.
- WAIT_ACK:
  - ACK with good CRC -> clear cpu_tx_pending, flip in_toggle, apply pending address if set; -> IDLE.
  - Any other packet or timeout -> IDLE; pending and toggle unchanged, so the host retry resends the same data.
- CPU side:
  - cpu_rx_release clears cpu_rx_ready and cpu_rx_setup next cycle; it is ignored while writes are enabled.
  - cpu_tx_arm sets cpu_tx_pending and latches endp/len; it is ignored while SEND_DATA/WAIT_ACK is active.
  - cpu_set_address latches the pending address; it takes effect only after the next ACKed IN (status stage).
- Simultaneous events: usb_reset has priority over everything; SETUP overwrite has priority over cpu_rx_release in the same cycle.

Optional Feature:
- Macro USB_ENDPOINT_STALL_EN.
- With it: adds input cpu_stall [NUM_ENDPOINTS-1:0]. OUT/IN to a stalled endpoint answers STALL instead of NAK/data. A SETUP to endpoint 0 is still accepted and clears cpu_stall's effect for endpoint 0 until the CPU re-asserts it.
- Without it: no port, STALL is never sent.

Test Plan:
- SETUP addr 0 ep 0 + DATA0 8 bytes, good CRC -> ACK sent, cpu_rx_ready=1, cpu_rx_setup=1, cpu_rx_len=8.
- OUT ep 1 DATA0 while cpu_rx_ready=1 -> NAK, cpu_rx_len unchanged. After release, OUT DATA0 -> ACK. Repeat DATA0 -> ACK, data discarded.
- IN ep 0 with nothing armed -> NAK. Arm len 0, IN -> DATA1 len 0. Host ACK -> cpu_tx_pending=0.
- cpu_set_address 5, then IN+ACK -> device_address 0 before ACK, 5 after. A token to addr 0 is then ignored.
- IN with data sent, no ACK for 72 clocks -> IDLE, pending still 1. Retry resends same DATAx PID.
- usb_reset during WAIT_DATA -> IDLE next cycle, device_address 0, rx_buffer_write_enable 0.
